// File: rtl/rx_pkg.sv
// Shared types and defaults for the UART RX frame counter and its pulse generator.
package rx_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StPulse
    } pulse_state_e;

    localparam int unsigned DefNBytes   = 9;
    localparam int unsigned DefPulseDly = 1;
    localparam int unsigned DefPulseLen = 2;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rx_pulse_gen.sv
// Delayed fixed-width pulse generator: trig -> PULSE_DLY idle cycles -> PULSE_LEN high cycles.
module rx_pulse_gen
    import rx_pkg::*;
#(
    parameter int unsigned PULSE_DLY = DefPulseDly,
    parameter int unsigned PULSE_LEN = DefPulseLen
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic trig,
    output logic pulse,
    output logic busy
);

    localparam int unsigned CntW = $clog2(max_u(PULSE_DLY, PULSE_LEN) + 1);
    localparam logic [CntW-1:0] DlyLd = CntW'(PULSE_DLY);
    localparam logic [CntW-1:0] LenLd = CntW'(PULSE_LEN);
    localparam logic [CntW-1:0] One   = CntW'(1);

    pulse_state_e    state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pulse_q, busy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (trig) begin
                    if (PULSE_DLY == 0) begin
                        state_d = StPulse;
                        cnt_d   = LenLd;
                    end else begin
                        state_d = StDelay;
                        cnt_d   = DlyLd;
                    end
                end
            end
            StDelay: begin
                if (cnt_q == One) begin
                    state_d = StPulse;
                    cnt_d   = LenLd;
                end else begin
                    cnt_d = cnt_q - One;
                end
            end
            StPulse: begin
                if (cnt_q == One) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - One;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
        if (clear) begin
            state_d = StIdle;
            cnt_d   = '0;
        end
    end

    // Outputs are flopped from next state so they change on the same edge as the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= (state_d == StPulse);
            busy_q  <= (state_d != StIdle);
        end
    end

    assign pulse = pulse_q;
    assign busy  = busy_q;

endmodule

// File: rtl/rx_frame_counter.sv
// Byte-frame counter for the UART RX path: counts data_ready strobes, flags frame
// completion and drives a delayed completion pulse.
module rx_frame_counter
    import rx_pkg::*;
#(
    parameter int unsigned N_BYTES      = DefNBytes,
    parameter int unsigned CNT_W        = $clog2(N_BYTES + 1),
    parameter int unsigned PULSE_DLY    = DefPulseDly,
    parameter int unsigned PULSE_LEN    = DefPulseLen,
    parameter int unsigned AUTO_RESTART = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             data_ready,
    output logic [CNT_W-1:0] count,
    output logic             hit,
    output logic             done_pulse,
    output logic             busy,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(N_BYTES - 1);
    localparam logic [CNT_W-1:0] FullCnt = CNT_W'(N_BYTES);
    localparam logic [CNT_W-1:0] One     = CNT_W'(1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             hit_q, hit_d;
    logic             ovf_q, ovf_d;
    logic             term_q, term_d;
    logic             term;
    logic             gen_busy;

    assign term = data_ready && (count_q == LastCnt);

    always_comb begin
        count_d = count_q;
        hit_d   = hit_q;
        ovf_d   = ovf_q;
        term_d  = 1'b0;
        if (AUTO_RESTART != 0) begin
            hit_d = 1'b0;
            if (data_ready) begin
                if (term) begin
                    count_d = '0;
                    hit_d   = 1'b1;
                    // A completion while a pulse is still running is dropped, not retriggered.
                    if (gen_busy) begin
                        ovf_d = 1'b1;
                    end else begin
                        term_d = 1'b1;
                    end
                end else begin
                    count_d = count_q + One;
                end
            end
        end else if (data_ready) begin
            if (count_q == FullCnt) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + One;
                if (term) begin
                    hit_d  = 1'b1;
                    term_d = 1'b1;
                end
            end
        end
        if (clear) begin
            count_d = '0;
            hit_d   = 1'b0;
            ovf_d   = 1'b0;
            term_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            hit_q   <= 1'b0;
            ovf_q   <= 1'b0;
            term_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            hit_q   <= hit_d;
            ovf_q   <= ovf_d;
            term_q  <= term_d;
        end
    end

    rx_pulse_gen #(
        .PULSE_DLY(PULSE_DLY),
        .PULSE_LEN(PULSE_LEN)
    ) u_pulse_gen (
        .clk  (clk),
        .rst  (rst),
        .clear(clear),
        .trig (term_q),
        .pulse(done_pulse),
        .busy (gen_busy)
    );

    assign count    = count_q;
    assign hit      = hit_q;
    assign busy     = gen_busy;
    assign overflow = ovf_q;

endmodule
